// File: rtl/regfile_pkg.sv
// Widths and constants for the architectural register file.
// The ROB, reservation stations, LSB and issue logic use these same definitions.
package regfile_pkg;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int Q_WIDTH        = 5;
  localparam int XLEN           = 32;
  localparam int ZERO_REG       = 0;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational source-operand read: register mux, x0 forced to zero, same-cycle commit bypass.
// Zero latency; has no flow control, so it never stalls.
module regfile_read_port #(
  parameter int REG_ADDR_WIDTH = regfile_pkg::REG_ADDR_WIDTH,
  parameter int Q_WIDTH        = regfile_pkg::Q_WIDTH,
  parameter int NREG           = 1 << REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0]                 rs_addr,
  input  logic [NREG-1:0][regfile_pkg::XLEN-1:0]    reg_v,
  input  logic [NREG-1:0]                           reg_busy,
  input  logic [NREG-1:0][Q_WIDTH-1:0]              reg_q,
  input  logic                                      has_commit,
  input  logic [REG_ADDR_WIDTH-1:0]                 commit_rd,
  input  logic [Q_WIDTH-1:0]                        commit_q,
  input  logic [regfile_pkg::XLEN-1:0]              commit_v,
  output logic                                      rs_busy,
  output logic [Q_WIDTH-1:0]                        rs_q,
  output logic [regfile_pkg::XLEN-1:0]              rs_v
);
  import regfile_pkg::*;

  logic bypass_hit;

  always_comb begin
    bypass_hit = has_commit && (commit_rd == rs_addr) && (commit_q == reg_q[rs_addr]);
    rs_busy    = 1'b0;
    rs_q       = '0;
    rs_v       = '0;
    if (rs_addr != REG_ADDR_WIDTH'(ZERO_REG)) begin
      // Tag and value are only meaningful one at a time; the other field reads as zero.
      if (reg_busy[rs_addr] && !bypass_hit) begin
        rs_busy = 1'b1;
        rs_q    = reg_q[rs_addr];
      end else if (reg_busy[rs_addr]) begin
        rs_v = commit_v;
      end else begin
        rs_v = reg_v[rs_addr];
      end
    end
  end
endmodule

// File: rtl/regfile.sv
// Architectural register file with per-register busy bit and ROB tag; renamed at issue, written at commit.
// Reads are combinational; rdy_in low freezes all state while reads and commit bypass keep working.
module regfile #(
  parameter int REG_ADDR_WIDTH = regfile_pkg::REG_ADDR_WIDTH,
  parameter int Q_WIDTH        = regfile_pkg::Q_WIDTH
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          issue_en,
  input  logic [REG_ADDR_WIDTH-1:0]     issue_rd,
  input  logic [Q_WIDTH-1:0]            issue_Q,
  input  logic [REG_ADDR_WIDTH-1:0]     rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0]     rs2_addr,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  output logic [Q_WIDTH-1:0]            rs1_Q,
  output logic [Q_WIDTH-1:0]            rs2_Q,
  output logic [regfile_pkg::XLEN-1:0]  rs1_V,
  output logic [regfile_pkg::XLEN-1:0]  rs2_V,
  input  logic                          has_commit,
  input  logic [REG_ADDR_WIDTH-1:0]     Commit_rd,
  input  logic [Q_WIDTH-1:0]            Commit_Q,
  input  logic [regfile_pkg::XLEN-1:0]  Commit_V,
  input  logic                          flush
);
  import regfile_pkg::*;

  localparam int NREG = 1 << REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] X0 = REG_ADDR_WIDTH'(ZERO_REG);

  logic [NREG-1:0][XLEN-1:0]    reg_q, reg_d;
  logic [NREG-1:0]              busy_q, busy_d;
  logic [NREG-1:0][Q_WIDTH-1:0] tag_q, tag_d;

  always_comb begin
    reg_d  = reg_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy_in) begin
      if (has_commit && Commit_rd != X0) begin
        reg_d[Commit_rd] = Commit_V;
        // A younger rename of the same register must stay busy.
        if (busy_q[Commit_rd] && tag_q[Commit_rd] == Commit_Q)
          busy_d[Commit_rd] = 1'b0;
      end
      if (issue_en && issue_rd != X0 && !flush) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_Q;
      end
      if (flush)
        busy_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      reg_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      reg_q  <= reg_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  regfile_read_port #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH), .Q_WIDTH(Q_WIDTH), .NREG(NREG)) u_rd1 (
    .rs_addr(rs1_addr), .reg_v(reg_q), .reg_busy(busy_q), .reg_q(tag_q),
    .has_commit(has_commit), .commit_rd(Commit_rd), .commit_q(Commit_Q), .commit_v(Commit_V),
    .rs_busy(rs1_busy), .rs_q(rs1_Q), .rs_v(rs1_V)
  );

  regfile_read_port #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH), .Q_WIDTH(Q_WIDTH), .NREG(NREG)) u_rd2 (
    .rs_addr(rs2_addr), .reg_v(reg_q), .reg_busy(busy_q), .reg_q(tag_q),
    .has_commit(has_commit), .commit_rd(Commit_rd), .commit_q(Commit_Q), .commit_v(Commit_V),
    .rs_busy(rs2_busy), .rs_q(rs2_Q), .rs_v(rs2_V)
  );
endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: expected read results are queued with each stimulus and popped on sampling.
module tb_regfile;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, issue_en, has_commit, flush;
  logic [4:0]  issue_rd, rs1_addr, rs2_addr, Commit_rd;
  logic [4:0]  issue_Q, Commit_Q;
  logic [31:0] Commit_V;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  rs1_Q, rs2_Q;
  logic [31:0] rs1_V, rs2_V;

  typedef struct {
    int          port;
    string       tag;
    logic        busy;
    logic [4:0]  q;
    logic [31:0] v;
    logic        chk_v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_in = ~clk_in;

  regfile dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_Q(issue_Q),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_Q(rs1_Q), .rs2_Q(rs2_Q),
    .rs1_V(rs1_V), .rs2_V(rs2_V),
    .has_commit(has_commit), .Commit_rd(Commit_rd), .Commit_Q(Commit_Q), .Commit_V(Commit_V),
    .flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic expect_rd(input int port, input string tag, input logic busy,
                           input logic [4:0] q, input logic [31:0] v);
    exp_t e;
    e.port = port; e.tag = tag; e.busy = busy; e.q = q; e.v = v;
    e.chk_v = !busy;
    exp_q.push_back(e);
  endtask

  task automatic compare_all();
    exp_t e;
    #2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.port == 1) begin
        check({e.tag, ".busy"}, 32'(rs1_busy), 32'(e.busy));
        check({e.tag, ".q"}, 32'(rs1_Q), 32'(e.q));
        if (e.chk_v) check({e.tag, ".v"}, rs1_V, e.v);
      end else begin
        check({e.tag, ".busy"}, 32'(rs2_busy), 32'(e.busy));
        check({e.tag, ".q"}, 32'(rs2_Q), 32'(e.q));
        if (e.chk_v) check({e.tag, ".v"}, rs2_V, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    issue_en = 1'b0; has_commit = 1'b0; flush = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [4:0] q);
    issue_en = 1'b1; issue_rd = rd; issue_Q = q;
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [4:0] q, input logic [31:0] v);
    has_commit = 1'b1; Commit_rd = rd; Commit_Q = q; Commit_V = v;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    rs1_addr = a1; rs2_addr = a2;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; issue_en = 1'b0; has_commit = 1'b0; flush = 1'b0;
    issue_rd = '0; issue_Q = '0; Commit_rd = '0; Commit_Q = '0; Commit_V = '0;
    rs1_addr = '0; rs2_addr = '0;
    tick(); tick();
    rst_in = 1'b0;

    rd(5'd5, 5'd0);
    expect_rd(1, "rst_x5", 1'b0, 5'd0, 32'd0);
    expect_rd(2, "rst_x0", 1'b0, 5'd0, 32'd0);
    compare_all();

    // Rename x3, then retire it with a same-cycle bypass
    do_issue(5'd3, 5'd7); tick();
    rd(5'd3, 5'd3);
    expect_rd(1, "x3_busy", 1'b1, 5'd7, 32'd0);
    compare_all();
    do_commit(5'd3, 5'd7, 32'h1234);
    expect_rd(1, "x3_bypass", 1'b0, 5'd0, 32'h1234);
    expect_rd(2, "x3_bypass2", 1'b0, 5'd0, 32'h1234);
    compare_all();
    tick();
    expect_rd(1, "x3_stored", 1'b0, 5'd0, 32'h1234);
    compare_all();

    // Older commit must not clear a younger rename
    do_issue(5'd4, 5'd2); tick();
    do_issue(5'd4, 5'd9); tick();
    rd(5'd4, 5'd3);
    do_commit(5'd4, 5'd2, 32'hAA);
    expect_rd(1, "x4_nobypass", 1'b1, 5'd9, 32'd0);
    compare_all();
    tick();
    expect_rd(1, "x4_still_busy", 1'b1, 5'd9, 32'd0);
    compare_all();
    flush = 1'b1; tick();
    expect_rd(1, "x4_val_aa", 1'b0, 5'd0, 32'hAA);
    compare_all();

    // Commit and issue to the same register in one cycle
    do_commit(5'd6, 5'd1, 32'h55);
    do_issue(5'd6, 5'd3); tick();
    rd(5'd6, 5'd4);
    expect_rd(1, "x6_issue_wins", 1'b1, 5'd3, 32'd0);
    compare_all();
    flush = 1'b1; tick();
    expect_rd(1, "x6_val_55", 1'b0, 5'd0, 32'h55);
    compare_all();

    // x0 ignores issue and commit
    do_issue(5'd0, 5'd4);
    do_commit(5'd0, 5'd4, 32'hFF);
    rd(5'd0, 5'd0);
    expect_rd(2, "x0_same_cycle", 1'b0, 5'd0, 32'd0);
    compare_all();
    tick();
    expect_rd(1, "x0_after", 1'b0, 5'd0, 32'd0);
    compare_all();

    // Flush drops renames and the same-cycle issue, but not the commit value
    do_issue(5'd1, 5'd10); tick();
    do_issue(5'd2, 5'd11); tick();
    rd(5'd1, 5'd2);
    expect_rd(1, "x1_pre_flush", 1'b1, 5'd10, 32'd0);
    expect_rd(2, "x2_pre_flush", 1'b1, 5'd11, 32'd0);
    compare_all();
    flush = 1'b1;
    do_issue(5'd8, 5'd5);
    do_commit(5'd9, 5'd0, 32'h99);
    tick();
    expect_rd(1, "x1_flushed", 1'b0, 5'd0, 32'd0);
    expect_rd(2, "x2_flushed", 1'b0, 5'd0, 32'd0);
    compare_all();
    rd(5'd8, 5'd9);
    expect_rd(1, "x8_dropped", 1'b0, 5'd0, 32'd0);
    expect_rd(2, "x9_flush_commit", 1'b0, 5'd0, 32'h99);
    compare_all();

    // rdy_in low freezes state
    rdy_in = 1'b0;
    do_issue(5'd10, 5'd6);
    do_commit(5'd11, 5'd0, 32'h77);
    tick();
    rd(5'd10, 5'd11);
    expect_rd(1, "x10_held", 1'b0, 5'd0, 32'd0);
    expect_rd(2, "x11_held", 1'b0, 5'd0, 32'd0);
    compare_all();
    rdy_in = 1'b1;
    do_issue(5'd10, 5'd6);
    do_commit(5'd11, 5'd0, 32'h77);
    tick();
    expect_rd(1, "x10_issued", 1'b1, 5'd6, 32'd0);
    expect_rd(2, "x11_committed", 1'b0, 5'd0, 32'h77);
    compare_all();

    // Reset overrides everything, including rdy_in low and a pending issue
    rst_in = 1'b1; rdy_in = 1'b0;
    do_issue(5'd12, 5'd3);
    tick();
    rst_in = 1'b0; rdy_in = 1'b1;
    rd(5'd10, 5'd11);
    expect_rd(1, "x10_reset", 1'b0, 5'd0, 32'd0);
    expect_rd(2, "x11_reset", 1'b0, 5'd0, 32'd0);
    compare_all();
    rd(5'd12, 5'd3);
    expect_rd(1, "x12_reset", 1'b0, 5'd0, 32'd0);
    expect_rd(2, "x3_reset", 1'b0, 5'd0, 32'd0);
    compare_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
